seg_scan_ctrl: RTL and testbench

- Time-multiplexes one shared hex_to_7seg decoder across NUM_DIGITS digits of a common-anode multi-digit display.
- Holds a double-buffered display value and steps through the digits in order.
- For each digit it drives the nibble into the decoder, waits out an anti-ghosting blank interval, then enables that digit's anode with the decoded segments.
- Sits between the register/control logic that writes values and the board-level display pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Segment bit order matches the decoder output: a..g at 0..6, dp at 7, active-low.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // All digit segments (a..g) without the decimal point; OR-ing blanks a digit.
   localparam logic [7:0] SEG_DIGIT_MSK = 8'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                             (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                             (1 << SEG_G));

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder, with a
// blanking gap per slot, double-buffered display value and leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_suppress,
   output logic [3:0]              dec_a,
   input  logic [7:0]              dec_d,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done,
   output logic                    upd_pending
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_e               state_q;
   logic [IDX_W-1:0]          idx_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [4*NUM_DIGITS-1:0]   act_val_q, shd_val_q;
   logic [NUM_DIGITS-1:0]     act_dp_q, shd_dp_q;
   logic                      pend_q;
   logic [3:0]                dec_a_q;
   logic [7:0]                seg_q;
   logic [NUM_DIGITS-1:0]     an_q;
   logic                      fd_q;

   logic                      last_digit;
   logic [IDX_W-1:0]          idx_d;
   logic                      boundary;
   logic                      xfer;
   logic [4*NUM_DIGITS-1:0]   act_val_d;
   logic [NUM_DIGITS-1:0]     act_dp_d;
   logic [NUM_DIGITS-1:0]     supp;
   logic                      allz;
   logic [7:0]                show_seg;

   always_comb begin
      last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
      idx_d      = last_digit ? '0 : idx_q + IDX_W'(1);
      boundary   = enable && ((state_q == IDLE) ||
                              (state_q == SHOW && cnt_q == CNT_LAST && last_digit));
      xfer       = boundary && pend_q;
      // The nibble launched on a boundary edge must come from the value being promoted.
      act_val_d  = xfer ? shd_val_q : act_val_q;
      act_dp_d   = xfer ? shd_dp_q  : act_dp_q;
   end

   always_comb begin
      supp = '0;
      allz = 1'b1;
      for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
         allz    = allz & (act_val_q[4*k +: 4] == 4'h0);
         supp[k] = lz_suppress & allz;
      end
   end

   always_comb begin
      show_seg = dec_d;
      if (supp[idx_q]) show_seg = show_seg | SEG_DIGIT_MSK;
      show_seg[SEG_DP] = ~act_dp_q[idx_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         act_val_q <= '0;
         act_dp_q  <= '0;
         shd_val_q <= '0;
         shd_dp_q  <= '0;
         pend_q    <= 1'b0;
         dec_a_q   <= '0;
         seg_q     <= SEG_OFF;
         an_q      <= '1;
         fd_q      <= 1'b0;
      end else begin
         fd_q <= 1'b0;
         if (xfer) begin
            act_val_q <= shd_val_q;
            act_dp_q  <= shd_dp_q;
         end
         // A load on the boundary edge is kept pending for the following frame.
         if (load) begin
            shd_val_q <= value;
            shd_dp_q  <= dp_mask;
            pend_q    <= 1'b1;
         end else if (xfer) begin
            pend_q <= 1'b0;
         end

         if (!enable) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= BLANK;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  dec_a_q <= act_val_d[3:0];
                  an_q    <= '1;
                  seg_q   <= SEG_OFF;
               end
               BLANK: begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == BLANK_LAST) begin
                     state_q <= SHOW;
                     an_q    <= ~(NUM_DIGITS'(1) << idx_q);
                     seg_q   <= show_seg;
                  end
               end
               SHOW: begin
                  if (cnt_q == CNT_LAST) begin
                     state_q <= BLANK;
                     cnt_q   <= '0;
                     idx_q   <= idx_d;
                     dec_a_q <= act_val_d[{idx_d, 2'b00} +: 4];
                     an_q    <= '1;
                     seg_q   <= SEG_OFF;
                     fd_q    <= last_digit;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                     seg_q <= show_seg;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  an_q    <= '1;
                  seg_q   <= SEG_OFF;
               end
            endcase
         end
      end
   end

   assign dec_a       = dec_a_q;
   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_done  = fd_q;
   assign upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a behavioural hex_to_7seg decoder attached.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        lz_suppress;
   logic [3:0]  dec_a;
   logic [7:0]  dec_d;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_done;
   logic        upd_pending;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .NUM_DIGITS  (4),
      .CLK_DIV     (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp_mask    (dp_mask),
      .lz_suppress(lz_suppress),
      .dec_a      (dec_a),
      .dec_d      (dec_d),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done),
      .upd_pending(upd_pending)
   );

   // Active-high gfedcba patterns of a conventional hex decoder.
   function automatic logic [6:0] hex_hi(input logic [3:0] n);
      case (n)
         4'h0: hex_hi = 7'h3F;  4'h1: hex_hi = 7'h06;
         4'h2: hex_hi = 7'h5B;  4'h3: hex_hi = 7'h4F;
         4'h4: hex_hi = 7'h66;  4'h5: hex_hi = 7'h6D;
         4'h6: hex_hi = 7'h7D;  4'h7: hex_hi = 7'h07;
         4'h8: hex_hi = 7'h7F;  4'h9: hex_hi = 7'h6F;
         4'hA: hex_hi = 7'h77;  4'hB: hex_hi = 7'h7C;
         4'hC: hex_hi = 7'h39;  4'hD: hex_hi = 7'h5E;
         4'hE: hex_hi = 7'h79;  default: hex_hi = 7'h71;
      endcase
   endfunction

   assign dec_d = {1'b1, ~hex_hi(dec_a)};

   function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                          input logic lz, input int d);
      logic       allz;
      logic       sup;
      logic [3:0] nib;
      allz = 1'b1;
      for (int k = 3; k >= d; k--) allz = allz & (v[4*k +: 4] == 4'h0);
      sup = lz && (d >= 1) && allz;
      nib = v[4*d +: 4];
      exp_seg = {~dp[d], sup ? 7'h7F : ~hex_hi(nib)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts at the sample just after a frame boundary edge; one sample per cycle.
   task automatic scan_frame(input string nm, input logic [15:0] v, input logic [3:0] dp,
                             input logic fd0, input logic p0, input logic p1, input int steps,
                             input logic early, input logic [15:0] ev, input logic [3:0] edp,
                             input logic late, input logic [15:0] lv, input logic [3:0] ldp);
      for (int n = 0; n < steps; n++) begin
         int         d;
         int         s;
         logic [3:0] an_e;
         logic [7:0] seg_e;
         d     = n / 8;
         s     = n % 8;
         an_e  = (s < 2) ? 4'hF : ~(4'b0001 << d);
         seg_e = (s < 2) ? 8'hFF : exp_seg(v, dp, lz_suppress, d);
         chk($sformatf("%s n%0d an", nm, n), 32'(an), 32'(an_e));
         chk($sformatf("%s n%0d seg", nm, n), 32'(seg), 32'(seg_e));
         chk($sformatf("%s n%0d frame_done", nm, n), 32'(frame_done), 32'((n == 0) ? fd0 : 1'b0));
         chk($sformatf("%s n%0d upd_pending", nm, n), 32'(upd_pending), 32'((n == 0) ? p0 : p1));
         if (n == 0 && early) begin
            load = 1'b1; value = ev; dp_mask = edp;
         end else if (n == steps - 1 && late) begin
            load = 1'b1; value = lv; dp_mask = ldp;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   initial begin
      logic fd_seen;
      logic an_leak;
      rst_n = 1'b0; enable = 1'b1; load = 1'b0;
      value = '0; dp_mask = '0; lz_suppress = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst an", 32'(an), 32'h0000_000F);
      chk("rst seg", 32'(seg), 32'h0000_00FF);
      chk("rst dec_a", 32'(dec_a), 32'h0);
      chk("rst frame_done", 32'(frame_done), 32'h0);
      chk("rst upd_pending", 32'(upd_pending), 32'h0);

      rst_n = 1'b1;
      @(negedge clk);
      scan_frame("f1", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32, 1'b0, '0, '0, 1'b0, '0, '0);
      scan_frame("f2", 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b1, 32, 1'b1, 16'h1A3F, 4'b0100, 1'b0, '0, '0);
      lz_suppress = 1'b1;
      scan_frame("f3", 16'h1A3F, 4'b0100, 1'b1, 1'b0, 1'b1, 32, 1'b1, 16'h0040, 4'b0000, 1'b0, '0, '0);
      scan_frame("f4", 16'h0040, 4'b0000, 1'b1, 1'b0, 1'b1, 32, 1'b1, 16'h2222, 4'b0000, 1'b1, 16'h5555, 4'b0000);
      scan_frame("f5", 16'h2222, 4'b0000, 1'b1, 1'b1, 1'b1, 32, 1'b0, '0, '0, 1'b0, '0, '0);
      scan_frame("f6", 16'h5555, 4'b0000, 1'b1, 1'b0, 1'b0, 32, 1'b0, '0, '0, 1'b0, '0, '0);

      scan_frame("f7", 16'h5555, 4'b0000, 1'b1, 1'b0, 1'b0, 20, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("f7 an before drop", 32'(an), 32'h0000_000B);
      enable = 1'b0;
      @(negedge clk);
      chk("drop an", 32'(an), 32'h0000_000F);
      chk("drop seg", 32'(seg), 32'h0000_00FF);
      chk("drop frame_done", 32'(frame_done), 32'h0);
      fd_seen = 1'b0;
      an_leak = 1'b0;
      repeat (20) begin
         @(negedge clk);
         fd_seen = fd_seen | frame_done;
         an_leak = an_leak | (an != 4'hF);
      end
      chk("idle frame_done", 32'(fd_seen), 32'h0);
      chk("idle an", 32'(an_leak), 32'h0);

      enable = 1'b1;
      @(negedge clk);
      scan_frame("f8", 16'h5555, 4'b0000, 1'b0, 1'b0, 1'b0, 32, 1'b0, '0, '0, 1'b0, '0, '0);

      scan_frame("f9", 16'h5555, 4'b0000, 1'b1, 1'b0, 1'b0, 4, 1'b0, '0, '0, 1'b0, '0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst an", 32'(an), 32'h0000_000F);
      chk("async rst seg", 32'(seg), 32'h0000_00FF);
      chk("async rst dec_a", 32'(dec_a), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      scan_frame("f10", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32, 1'b0, '0, '0, 1'b0, '0, '0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
